// File: rtl/sensor_rx.sv
// Sensor serial link receiver: deserialises LSB-first header/data/parity frames,
// flags header, parity and short-frame errors, and counts good and bad frames.
module sensor_rx #(
  parameter int         DATA_W = 8,
  parameter logic [2:0] HDR    = 3'b101,
  parameter int         CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_strobe,
  output logic              parity_err,
  output logic              sync_err,
  output logic              short_err,
  output logic [CNT_W-1:0]  good_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int SR_W  = DATA_W + 3;
  localparam int IDX_W = $clog2(DATA_W + 4);
  localparam logic [IDX_W-1:0] LAST_HDR  = IDX_W'(2);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_PAR,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              strobe_q, strobe_d;
  logic              perr_q, perr_d;
  logic              serr_q, serr_d;
  logic              short_q, short_d;
  logic [CNT_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              abort;

  assign abort = (state_q inside {S_HDR, S_DATA, S_PAR}) && !data_valid;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sr_d     = sr_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    perr_d   = 1'b0;
    serr_d   = 1'b0;
    short_d  = 1'b0;

    if (abort) begin
      short_d = 1'b1;
      idx_d   = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (data_valid) begin
            sr_d[0] = data_in;
            idx_d   = IDX_W'(1);
            state_d = S_HDR;
          end
        end
        S_HDR: begin
          sr_d[idx_q] = data_in;
          idx_d       = idx_q + IDX_W'(1);
          // The header is judged on the edge that brings in its last bit.
          if (idx_q == LAST_HDR) begin
            if (sr_d[2:0] != HDR) begin
              serr_d  = 1'b1;
              state_d = S_DRAIN;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          sr_d[idx_q] = data_in;
          idx_d       = idx_q + IDX_W'(1);
          if (idx_q == LAST_DATA) state_d = S_PAR;
        end
        S_PAR: begin
          if (data_in == ^sr_q[SR_W-1:3]) begin
            data_d   = sr_q[SR_W-1:3];
            strobe_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          idx_d   = '0;
          state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (!data_valid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    good_d = strobe_d ? good_q + CNT_W'(1) : good_q;
    err_d  = (perr_d || serr_d || short_d) ? err_q + CNT_W'(1) : err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      sr_q     <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
      short_q  <= 1'b0;
      good_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sr_q     <= sr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
      short_q  <= short_d;
      good_q   <= good_d;
      err_q    <= err_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_strobe  = strobe_q;
  assign parity_err = perr_q;
  assign sync_err   = serr_q;
  assign short_err  = short_q;
  assign good_count = good_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_sensor_rx.sv
// Directed bench for sensor_rx: good/parity/header/short/reset/long-run frames,
// plus a narrow-counter instance for the wrap sequence.
module tb_sensor_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        din = 1'b0;
  logic        vld = 1'b0;

  logic [7:0]  rx_data;
  logic        rx_strobe, parity_err, sync_err, short_err;
  logic [15:0] good_count, err_count;

  logic [7:0]  rx_data2;
  logic        rx_strobe2, parity_err2, sync_err2, short_err2;
  logic [1:0]  good_count2, err_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sensor_rx #(.DATA_W(8), .HDR(3'b101), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n), .data_in(din), .data_valid(vld),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .parity_err(parity_err),
    .sync_err(sync_err), .short_err(short_err),
    .good_count(good_count), .err_count(err_count)
  );

  sensor_rx #(.DATA_W(8), .HDR(3'b101), .CNT_W(2)) dut_wrap (
    .clk(clk), .reset(rst2_n), .data_in(din), .data_valid(vld),
    .rx_data(rx_data2), .rx_strobe(rx_strobe2), .parity_err(parity_err2),
    .sync_err(sync_err2), .short_err(short_err2),
    .good_count(good_count2), .err_count(err_count2)
  );

  // Frames written as {parity, data, header}; bit 0 goes out first.
  localparam logic [11:0] F_A5     = 12'h52D;
  localparam logic [11:0] F_A5_BAD = 12'hD2D;
  localparam logic [11:0] F_3C     = 12'h1E5;
  localparam logic [11:0] F_0F     = 12'h07D;
  localparam logic [11:0] F_BADHDR = 12'h0A7;

  task automatic send(input logic [11:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      din = v[i];
      vld = 1'b1;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      vld = 1'b0;
      din = 1'b0;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data got %h want 00", rx_data); n_bad++; end
    n_cmp++;
    if ({rx_strobe, parity_err, sync_err, short_err} !== 4'b0000) begin
      $display("FAIL reset_pulses got %b want 0000", {rx_strobe, parity_err, sync_err, short_err}); n_bad++;
    end
    n_cmp++;
    if (good_count !== 16'd0 || err_count !== 16'd0) begin
      $display("FAIL reset_counts got %0d/%0d want 0/0", good_count, err_count); n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame;
    send(F_A5, 12);
    if (rx_strobe !== 1'b1 || rx_data !== 8'hA5) begin
      $display("FAIL good_strobe got %b/%h want 1/a5", rx_strobe, rx_data); n_bad++;
    end
    n_cmp++;
    if (good_count !== 16'd1 || err_count !== 16'd0 || {parity_err, sync_err, short_err} !== 3'b000) begin
      $display("FAIL good_counts got %0d/%0d err=%b want 1/0 err=000", good_count, err_count,
               {parity_err, sync_err, short_err}); n_bad++;
    end
    n_cmp++;
    idle(1);
    if (rx_strobe !== 1'b0 || rx_data !== 8'hA5) begin
      $display("FAIL good_one_cycle got %b/%h want 0/a5", rx_strobe, rx_data); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_parity;
    send(F_A5_BAD, 12);
    if (parity_err !== 1'b1 || rx_strobe !== 1'b0 || rx_data !== 8'hA5) begin
      $display("FAIL parity_pulse got perr=%b stb=%b data=%h want 1/0/a5", parity_err, rx_strobe, rx_data); n_bad++;
    end
    n_cmp++;
    if (err_count !== 16'd1 || good_count !== 16'd1) begin
      $display("FAIL parity_counts got %0d/%0d want 1/1", good_count, err_count); n_bad++;
    end
    n_cmp++;
    idle(1);
    if (parity_err !== 1'b0) begin $display("FAIL parity_one_cycle got %b want 0", parity_err); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_bad_header;
    int unsigned extra;
    send(F_BADHDR, 3);
    if (sync_err !== 1'b1 || err_count !== 16'd2) begin
      $display("FAIL sync_pulse got %b cnt=%0d want 1 cnt=2", sync_err, err_count); n_bad++;
    end
    n_cmp++;
    extra = 0;
    for (int unsigned i = 3; i < 12; i++) begin
      @(negedge clk);
      din = F_BADHDR[i];
      @(posedge clk);
      #1;
      if (rx_strobe || parity_err || sync_err || short_err) extra++;
    end
    if (extra !== 0) begin $display("FAIL sync_drain got %0d pulses want 0", extra); n_bad++; end
    n_cmp++;
    idle(1);
    send(F_3C, 12);
    if (rx_strobe !== 1'b1 || rx_data !== 8'h3C || good_count !== 16'd2) begin
      $display("FAIL after_sync got %b/%h/%0d want 1/3c/2", rx_strobe, rx_data, good_count); n_bad++;
    end
    n_cmp++;
    idle(1);
  endtask

  task automatic test_short_and_reset;
    send(F_A5, 7);
    idle(1);
    if (short_err !== 1'b1 || err_count !== 16'd3 || rx_data !== 8'h3C || rx_strobe !== 1'b0) begin
      $display("FAIL short_pulse got %b cnt=%0d data=%h stb=%b want 1/3/3c/0", short_err, err_count, rx_data, rx_strobe);
      n_bad++;
    end
    n_cmp++;
    idle(1);
    if (short_err !== 1'b0) begin $display("FAIL short_one_cycle got %b want 0", short_err); n_bad++; end
    n_cmp++;
    // A short frame must leave the receiver ready for an immediate new frame.
    send(F_0F, 12);
    if (rx_strobe !== 1'b1 || rx_data !== 8'h0F || good_count !== 16'd3) begin
      $display("FAIL after_short got %b/%h/%0d want 1/0f/3", rx_strobe, rx_data, good_count); n_bad++;
    end
    n_cmp++;
    idle(1);
    send(F_A5, 5);
    @(negedge clk);
    rst_n = 1'b0;
    vld = 1'b0;
    #1;
    if (rx_data !== 8'h00 || good_count !== 16'd0 || err_count !== 16'd0 ||
        {rx_strobe, parity_err, sync_err, short_err} !== 4'b0000) begin
      $display("FAIL midframe_reset got %h/%0d/%0d pulses=%b want 00/0/0/0000", rx_data, good_count, err_count,
               {rx_strobe, parity_err, sync_err, short_err}); n_bad++;
    end
    n_cmp++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    if ({rx_strobe, parity_err, sync_err, short_err} !== 4'b0000 || err_count !== 16'd0) begin
      $display("FAIL reset_release got pulses=%b cnt=%0d want 0000/0", {rx_strobe, parity_err, sync_err, short_err},
               err_count); n_bad++;
    end
    n_cmp++;
    send(F_3C, 12);
    if (rx_strobe !== 1'b1 || rx_data !== 8'h3C || good_count !== 16'd1) begin
      $display("FAIL post_reset_frame got %b/%h/%0d want 1/3c/1", rx_strobe, rx_data, good_count); n_bad++;
    end
    n_cmp++;
    idle(1);
  endtask

  task automatic test_long_run;
    logic [7:0]  junk;
    int unsigned extra;
    junk = 8'hAD;
    send(F_0F, 12);
    if (rx_strobe !== 1'b1 || rx_data !== 8'h0F || good_count !== 16'd2) begin
      $display("FAIL long_frame got %b/%h/%0d want 1/0f/2", rx_strobe, rx_data, good_count); n_bad++;
    end
    n_cmp++;
    extra = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      din = junk[i];
      @(posedge clk);
      #1;
      if (rx_strobe || parity_err || sync_err || short_err) extra++;
    end
    if (extra !== 0) begin $display("FAIL long_junk got %0d pulses want 0", extra); n_bad++; end
    n_cmp++;
    idle(1);
    if (good_count !== 16'd2 || err_count !== 16'd0 || rx_data !== 8'h0F) begin
      $display("FAIL long_after got %0d/%0d/%h want 2/0/0f", good_count, err_count, rx_data); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_wrap;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    @(negedge clk);
    rst2_n = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      send(F_A5, 12);
      if (rx_strobe2 !== 1'b1 || good_count2 !== exp_cnt[k] || rx_data2 !== 8'hA5) begin
        $display("FAIL wrap_%0d got %b/%0d/%h want 1/%0d/a5", k, rx_strobe2, good_count2, rx_data2, exp_cnt[k]);
        n_bad++;
      end
      n_cmp++;
      idle(1);
    end
    if (err_count2 !== 2'd0 || {parity_err2, sync_err2, short_err2} !== 3'b000) begin
      $display("FAIL wrap_errs got %0d/%b want 0/000", err_count2, {parity_err2, sync_err2, short_err2}); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_bad_header();
    test_short_and_reset();
    test_long_run();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
